// File: rtl/input_conditioner_debounce_bit.sv
// One conditioned input bit: 2-flop synchroniser, saturating debounce counter,
// stable level and registered rise/fall pulses aligned with the level change.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_WIDTH       = 20,
  parameter logic        IDLE            = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync1_q, sync2_q;
  logic                 stable_q, stable_d;
  logic                 rise_q, fall_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Any cycle where the synced input agrees with the stable value restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) stable_d = sync2_q;
      else                  cnt_d    = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= IDLE;
      sync2_q  <= IDLE;
      stable_q <= IDLE;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= ~stable_q & stable_d;
      fall_q   <= stable_q & ~stable_d;
    end
  end

  assign level = stable_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
endmodule

// File: rtl/input_conditioner.sv
// Board input conditioning: per-bit sync/debounce/edge detect for active-low
// push-buttons and active-high slide switches.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned BTN_WIDTH       = 3,
  parameter int unsigned SW_WIDTH        = 10,
  parameter int unsigned CNT_WIDTH       = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BTN_WIDTH-1:0] btn_raw,
  input  logic [SW_WIDTH-1:0]  sw_raw,
  output logic [BTN_WIDTH-1:0] btn_level,
  output logic [BTN_WIDTH-1:0] btn_press,
  output logic [BTN_WIDTH-1:0] btn_release,
  output logic [SW_WIDTH-1:0]  sw_level,
  output logic                 sw_changed
);
  localparam logic BTN_IDLE = 1'b1;
  localparam logic SW_IDLE  = 1'b0;

  logic [BTN_WIDTH-1:0] btn_lvl_raw, btn_rise_raw, btn_fall_raw;
  logic [SW_WIDTH-1:0]  sw_rise, sw_fall;

  // Buttons are debounced in raw (active-low) polarity so the sync flops idle high;
  // inverting afterwards turns a raw fall into a press.
  for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_btn
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_WIDTH(CNT_WIDTH), .IDLE(BTN_IDLE)
    ) u_db (
      .clk(clk), .rst_n(rst_n), .raw(btn_raw[i]),
      .level(btn_lvl_raw[i]), .rise(btn_rise_raw[i]), .fall(btn_fall_raw[i])
    );
  end

  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_WIDTH(CNT_WIDTH), .IDLE(SW_IDLE)
    ) u_db (
      .clk(clk), .rst_n(rst_n), .raw(sw_raw[i]),
      .level(sw_level[i]), .rise(sw_rise[i]), .fall(sw_fall[i])
    );
  end

  assign btn_level   = ~btn_lvl_raw;
  assign btn_press   = btn_fall_raw;
  assign btn_release = btn_rise_raw;
  assign sw_changed  = |(sw_rise | sw_fall);
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4 (level lands 5 edges after sampling).
module tb_input_conditioner;
  localparam int BW = 3;
  localparam int SW = 10;

  typedef struct packed {
    logic [BW-1:0] lvl;
    logic [BW-1:0] prs;
    logic [BW-1:0] rel;
    logic [SW-1:0] swl;
    logic          chg;
  } outs_t;

  typedef struct packed {
    logic [BW-1:0] b;
    logic [SW-1:0] s;
    outs_t         e;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [BW-1:0] btn_raw = '1;
  logic [SW-1:0] sw_raw = '0;
  logic [BW-1:0] btn_level, btn_press, btn_release;
  logic [SW-1:0] sw_level;
  logic          sw_changed;
  outs_t         act;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[$];

  input_conditioner #(
    .DEBOUNCE_CYCLES(4), .BTN_WIDTH(BW), .SW_WIDTH(SW), .CNT_WIDTH(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .sw_level(sw_level), .sw_changed(sw_changed)
  );

  always #5 clk = ~clk;

  assign act = {btn_level, btn_press, btn_release, sw_level, sw_changed};

  function automatic outs_t mko(input logic [BW-1:0] l, input logic [BW-1:0] p,
                                input logic [BW-1:0] r, input logic [SW-1:0] s,
                                input logic c);
    mko = {l, p, r, s, c};
  endfunction

  function automatic vec_t mkv(input logic [BW-1:0] b, input logic [SW-1:0] s, input outs_t e);
    mkv = {b, s, e};
  endfunction

  task automatic chk(input string name, input outs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got lvl=%b prs=%b rel=%b swl=%h chg=%b, want lvl=%b prs=%b rel=%b swl=%h chg=%b",
               name, act.lvl, act.prs, act.rel, act.swl, act.chg,
               exp.lvl, exp.prs, exp.rel, exp.swl, exp.chg);
    end
  endtask

  task automatic step(input logic [BW-1:0] b, input logic [SW-1:0] s);
    btn_raw = b;
    sw_raw  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [BW-1:0] b, input logic [SW-1:0] s);
    rst_n   = 1'b0;
    btn_raw = b;
    sw_raw  = s;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_zero", '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int pulses;
    logic [SW-1:0] bounce [11];
    outs_t z;
    z = '0;

    // Buttons held pressed and switches on through reset: one press / change after release.
    do_reset(3'b000, 10'h3FF);
    for (int k = 0; k < 7; k++) begin
      step(3'b000, 10'h3FF);
      if (k < 5)       chk("held_rst_wait", z);
      else if (k == 5) chk("held_rst_edge", mko(3'b111, 3'b111, 3'b000, 10'h3FF, 1'b1));
      else             chk("held_rst_after", mko(3'b111, 3'b000, 3'b000, 10'h3FF, 1'b0));
    end

    // Clean press/release on btn0, glitch rejection and minimum press on btn1.
    do_reset(3'b111, 10'h000);
    for (int i = 0; i < 5; i++) tbl.push_back(mkv(3'b110, 0, z));
    tbl.push_back(mkv(3'b110, 0, mko(3'b001, 3'b001, 3'b000, 0, 1'b0)));
    tbl.push_back(mkv(3'b110, 0, mko(3'b001, 3'b000, 3'b000, 0, 1'b0)));
    for (int i = 7; i < 12; i++) tbl.push_back(mkv(3'b111, 0, mko(3'b001, 0, 0, 0, 1'b0)));
    tbl.push_back(mkv(3'b111, 0, mko(3'b000, 3'b000, 3'b001, 0, 1'b0)));
    tbl.push_back(mkv(3'b111, 0, z));
    for (int i = 14; i < 17; i++) tbl.push_back(mkv(3'b101, 0, z));
    for (int i = 17; i < 21; i++) tbl.push_back(mkv(3'b111, 0, z));
    for (int i = 21; i < 25; i++) tbl.push_back(mkv(3'b101, 0, z));
    tbl.push_back(mkv(3'b111, 0, z));
    tbl.push_back(mkv(3'b111, 0, mko(3'b010, 3'b010, 3'b000, 0, 1'b0)));
    for (int i = 27; i < 30; i++) tbl.push_back(mkv(3'b111, 0, mko(3'b010, 0, 0, 0, 1'b0)));
    tbl.push_back(mkv(3'b111, 0, mko(3'b000, 3'b000, 3'b010, 0, 1'b0)));
    tbl.push_back(mkv(3'b111, 0, z));
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].b, tbl[i].s);
      chk($sformatf("tbl[%0d]", i), tbl[i].e);
    end

    // Switch bounce: sw3 toggles then settles high on edge F4; one change at F9.
    bounce = '{10'h008, 10'h000, 10'h008, 10'h000, 10'h008, 10'h008,
               10'h008, 10'h008, 10'h008, 10'h008, 10'h008};
    pulses = 0;
    for (int k = 0; k < 11; k++) begin
      step(3'b111, bounce[k]);
      if (sw_changed) pulses++;
      if (k < 9)       chk("bounce_wait", z);
      else if (k == 9) chk("bounce_edge", mko(0, 0, 0, 10'h008, 1'b1));
      else             chk("bounce_after", mko(0, 0, 0, 10'h008, 1'b0));
    end
    n_vec++;
    if (pulses != 1) begin
      n_bad++;
      $display("FAIL bounce_pulse_count: got %0d, want 1", pulses);
    end

    // Button and two switches change on the same edge.
    for (int k = 0; k < 8; k++) begin
      step(3'b011, 10'h209);
      if (k < 5)       chk("simul_wait", mko(0, 0, 0, 10'h008, 1'b0));
      else if (k == 5) chk("simul_edge", mko(3'b100, 3'b100, 3'b000, 10'h209, 1'b1));
      else             chk("simul_after", mko(3'b100, 3'b000, 3'b000, 10'h209, 1'b0));
    end

    // Release btn2 and reset after two mismatch cycles: outputs clear, no stale pulse.
    for (int k = 0; k < 4; k++) begin
      step(3'b111, 10'h209);
      chk("midrst_pre", mko(3'b100, 0, 0, 10'h209, 1'b0));
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_async", z);
    btn_raw = 3'b111;
    sw_raw  = 10'h000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(3'b111, 10'h000);
      chk("midrst_post", z);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
